// File: rtl/write_rx_pkg.sv
// write_rx_pkg
//   Shared constants and helpers for the write data receiver.
//   - DEFAULT_DATA_W : default payload width in bits
//   - DEFAULT_DEPTH  : default buffer depth (power of two, >= 2)
//   - level_width()  : bits needed to hold an occupancy of 0..depth
package write_rx_pkg;

  localparam int DEFAULT_DATA_W = 8;
  localparam int DEFAULT_DEPTH  = 4;

  // The occupancy counter has to represent DEPTH itself, hence depth+1.
  function automatic int level_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/write_rx_mem.sv
// write_rx_mem
//   DEPTH x DATA_W register array used as the receive buffer storage.
//   Ports:
//     clk   - clock, writes on posedge
//     we    - write enable
//     waddr - write address
//     wdata - write data
//     raddr - asynchronous read address
//     rdata - asynchronous read data (mem[raddr])
//   The array has no reset; validity is tracked by the controller.
module write_rx_mem
  import write_rx_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int DEPTH  = DEFAULT_DEPTH
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [DATA_W-1:0]        rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/write_data_receiver.sv
// write_data_receiver
//   Receives an unthrottled write stream into a small first-word-fall-through
//   FIFO. Writes arriving while full (and not draining) are dropped and
//   flagged on a sticky overflow bit.
//   Ports:
//     clk          - clock
//     rst_n        - asynchronous active-low reset
//     write_valid  - write strobe (no backpressure)
//     write_data   - write payload
//     read_valid   - head entry available
//     read_data    - head entry payload (0 when empty)
//     read_ready   - consumer accepts head entry
//     level        - current occupancy 0..DEPTH
//     overflow     - sticky: a write was dropped
//     overflow_clr - synchronous clear of overflow (a same-cycle drop wins)
//     rx_count     - 16-bit wrapping count of accepted writes
module write_data_receiver
  import write_rx_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int DEPTH  = DEFAULT_DEPTH
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                write_valid,
  input  logic [DATA_W-1:0]                   write_data,
  output logic                                read_valid,
  output logic [DATA_W-1:0]                   read_data,
  input  logic                                read_ready,
  output logic [level_width(DEPTH)-1:0]       level,
  output logic                                overflow,
  input  logic                                overflow_clr,
  output logic [15:0]                         rx_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = level_width(DEPTH);

  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [LVL_W-1:0] LVL_ONE  = LVL_W'(1);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [DATA_W-1:0] mem_rdata;
  logic              full;
  logic              push;
  logic              pop;
  logic              drop;

  assign full       = (level == LVL_FULL);
  assign read_valid = (level != '0);
  assign pop        = read_valid & read_ready;
  // A full buffer can still take a write when the head leaves in the same cycle.
  assign push       = write_valid & (~full | pop);
  assign drop       = write_valid & full & ~pop;

  // Mask the unreset array so the output is defined whenever nothing is held.
  assign read_data  = read_valid ? mem_rdata : '0;

  write_rx_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (write_data),
    .raddr (rd_ptr),
    .rdata (mem_rdata)
  );

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
      rx_count <= '0;
    end else begin
      if (push) begin
        wr_ptr   <= wr_ptr + PTR_ONE;
        rx_count <= rx_count + 16'd1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   level <= level + LVL_ONE;
        2'b01:   level <= level - LVL_ONE;
        default: level <= level;
      endcase
      if (drop) begin
        overflow <= 1'b1;
      end else if (overflow_clr) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_write_data_receiver.sv
module tb_write_data_receiver;

  logic       clk;
  logic       rst_n;
  logic       write_valid;
  logic [7:0] write_data;
  logic       read_valid;
  logic [7:0] read_data;
  logic       read_ready;
  logic [2:0] level;
  logic       overflow;
  logic       overflow_clr;
  logic [15:0] rx_count;

  int total;
  int bad;

  write_data_receiver #(.DATA_W(8), .DEPTH(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .write_valid  (write_valid),
    .write_data   (write_data),
    .read_valid   (read_valid),
    .read_data    (read_data),
    .read_ready   (read_ready),
    .level        (level),
    .overflow     (overflow),
    .overflow_clr (overflow_clr),
    .rx_count     (rx_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n && read_valid) begin
      assert (!$isunknown(read_data))
        else $error("read_data unknown while read_valid");
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    #1 rst_n = 1'b0;
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; write_valid = 1'b0; write_data = 8'h00;
    read_ready = 1'b0; overflow_clr = 1'b0;
    #1;
    total++; if (read_valid !== 1'b0) begin bad++; $display("FAIL reset_read_valid got=%b exp=0", read_valid); end
    total++; if (level !== 3'd0) begin bad++; $display("FAIL reset_level got=%0d exp=0", level); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
    total++; if (rx_count !== 16'h0000) begin bad++; $display("FAIL reset_rx_count got=%h exp=0000", rx_count); end
    total++; if (read_data !== 8'h00) begin bad++; $display("FAIL reset_read_data got=%h exp=00", read_data); end
    step();
    rst_n = 1'b1;
  endtask

  // First posedge after release must accept the write.
  task automatic test_single_write();
    write_valid = 1'b1; write_data = 8'hA5; read_ready = 1'b0;
    step();
    write_valid = 1'b0; write_data = 8'hFF;
    total++; if (read_valid !== 1'b1) begin bad++; $display("FAIL single_read_valid got=%b exp=1", read_valid); end
    total++; if (read_data !== 8'hA5) begin bad++; $display("FAIL single_read_data got=%h exp=a5", read_data); end
    total++; if (level !== 3'd1) begin bad++; $display("FAIL single_level got=%0d exp=1", level); end
    total++; if (rx_count !== 16'd1) begin bad++; $display("FAIL single_rx_count got=%0d exp=1", rx_count); end
    // write_data toggling with write_valid low must not matter
    step();
    total++; if (level !== 3'd1) begin bad++; $display("FAIL idle_data_level got=%0d exp=1", level); end
    total++; if (read_data !== 8'hA5) begin bad++; $display("FAIL idle_data_hold got=%h exp=a5", read_data); end
    read_ready = 1'b1;
    step();
    read_ready = 1'b0;
    total++; if (level !== 3'd0) begin bad++; $display("FAIL single_drain_level got=%0d exp=0", level); end
  endtask

  task automatic test_order();
    logic [7:0] v;
    for (int i = 1; i <= 4; i++) begin
      v = 8'(i);
      write_valid = 1'b1; write_data = v;
      step();
      total++; if (read_data !== 8'h01) begin bad++; $display("FAIL order_head_hold_%0d got=%h exp=01", i, read_data); end
    end
    write_valid = 1'b0;
    total++; if (level !== 3'd4) begin bad++; $display("FAIL order_level_full got=%0d exp=4", level); end
    read_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      v = 8'(i);
      total++; if (read_valid !== 1'b1 || read_data !== v) begin bad++; $display("FAIL order_read_%0d got=%b/%h exp=1/%h", i, read_valid, read_data, v); end
      step();
    end
    total++; if (read_valid !== 1'b0) begin bad++; $display("FAIL order_empty_valid got=%b exp=0", read_valid); end
    total++; if (level !== 3'd0) begin bad++; $display("FAIL order_empty_level got=%0d exp=0", level); end
    // read_ready while empty has no effect
    step();
    total++; if (level !== 3'd0) begin bad++; $display("FAIL empty_pop_level got=%0d exp=0", level); end
    read_ready = 1'b0;
  endtask

  task automatic test_overflow();
    pulse_reset();
    for (int i = 0; i < 4; i++) begin
      write_valid = 1'b1; write_data = 8'h10 + 8'(i);
      step();
    end
    write_data = 8'h55;
    step();
    write_valid = 1'b0;
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_set got=%b exp=1", overflow); end
    total++; if (level !== 3'd4) begin bad++; $display("FAIL ovf_level got=%0d exp=4", level); end
    total++; if (rx_count !== 16'd4) begin bad++; $display("FAIL ovf_rx_count got=%0d exp=4", rx_count); end
    total++; if (read_data !== 8'h10) begin bad++; $display("FAIL ovf_head got=%h exp=10", read_data); end
    overflow_clr = 1'b1;
    step();
    overflow_clr = 1'b0;
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_clear got=%b exp=0", overflow); end
    // drop and clear together: set wins
    write_valid = 1'b1; write_data = 8'h77; overflow_clr = 1'b1;
    step();
    write_valid = 1'b0; overflow_clr = 1'b0;
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_set_wins got=%b exp=1", overflow); end
    overflow_clr = 1'b1;
    step();
    overflow_clr = 1'b0;
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_clear2 got=%b exp=0", overflow); end
  endtask

  // Continues from the full buffer 0x10..0x13 left by test_overflow.
  task automatic test_full_push_pop();
    logic [7:0] exp_q [4];
    exp_q[0] = 8'h11; exp_q[1] = 8'h12; exp_q[2] = 8'h13; exp_q[3] = 8'h66;
    write_valid = 1'b1; write_data = 8'h66; read_ready = 1'b1;
    step();
    write_valid = 1'b0; read_ready = 1'b0;
    total++; if (level !== 3'd4) begin bad++; $display("FAIL fpp_level got=%0d exp=4", level); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL fpp_overflow got=%b exp=0", overflow); end
    total++; if (rx_count !== 16'd5) begin bad++; $display("FAIL fpp_rx_count got=%0d exp=5", rx_count); end
    read_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      total++; if (read_data !== exp_q[i]) begin bad++; $display("FAIL fpp_read_%0d got=%h exp=%h", i, read_data, exp_q[i]); end
      step();
    end
    read_ready = 1'b0;
    total++; if (level !== 3'd0) begin bad++; $display("FAIL fpp_drained got=%0d exp=0", level); end
  endtask

  task automatic test_count_wrap();
    pulse_reset();
    write_valid = 1'b1; read_ready = 1'b1;
    for (int i = 0; i < 65535; i++) begin
      write_data = 8'(i);
      step();
    end
    total++; if (rx_count !== 16'hFFFF) begin bad++; $display("FAIL wrap_preload got=%h exp=ffff", rx_count); end
    total++; if (level !== 3'd1) begin bad++; $display("FAIL wrap_level got=%0d exp=1", level); end
    total++; if (read_data !== 8'hFE) begin bad++; $display("FAIL wrap_head got=%h exp=fe", read_data); end
    write_data = 8'hC3;
    step();
    write_valid = 1'b0;
    total++; if (rx_count !== 16'h0000) begin bad++; $display("FAIL wrap_rollover got=%h exp=0000", rx_count); end
    total++; if (read_data !== 8'hC3) begin bad++; $display("FAIL wrap_last got=%h exp=c3", read_data); end
    step();
    read_ready = 1'b0;
    total++; if (level !== 3'd0) begin bad++; $display("FAIL wrap_drain got=%0d exp=0", level); end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 3; i++) begin
      write_valid = 1'b1; write_data = 8'h20 + 8'(i);
      step();
    end
    write_valid = 1'b0;
    total++; if (level !== 3'd3) begin bad++; $display("FAIL areset_pre_level got=%0d exp=3", level); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (read_valid !== 1'b0) begin bad++; $display("FAIL areset_valid got=%b exp=0", read_valid); end
    total++; if (level !== 3'd0) begin bad++; $display("FAIL areset_level got=%0d exp=0", level); end
    total++; if (read_data !== 8'h00) begin bad++; $display("FAIL areset_data got=%h exp=00", read_data); end
    #3 rst_n = 1'b1;
    write_valid = 1'b1; write_data = 8'h3C;
    step();
    write_valid = 1'b0;
    total++; if (read_valid !== 1'b1 || read_data !== 8'h3C) begin bad++; $display("FAIL areset_first_read got=%b/%h exp=1/3c", read_valid, read_data); end
    total++; if (rx_count !== 16'd1) begin bad++; $display("FAIL areset_rx_count got=%0d exp=1", rx_count); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_single_write();
    test_order();
    test_overflow();
    test_full_push_pop();
    test_count_wrap();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
